// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: maps flow tags to stream IDs and sequences shared matcher control.
// Ports: in_* byte stream (valid/ready, sop/eop, 16-bit flow tag on sop), cfg_* enable-mask writes,
// stream_id/new_stream_id/load_state/char_in/char_in_vld/eop/enable to the matchers,
// busy (FSM not idle) and drop_cnt (saturating count of non-sop beats discarded while idle).
module dpi_stream_sequencer #(
  parameter int                   NUM_REGEX    = 8,
  parameter int                   DRAIN_CYCLES = 2,
  parameter logic [NUM_REGEX-1:0] DEFAULT_EN   = {NUM_REGEX{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [7:0]           in_data,
  input  logic [15:0]          in_flow_tag,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_en,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic                 load_state,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic [NUM_REGEX-1:0] enable,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, SETTLE, STREAM, DRAIN, EOP} state_e;
  state_e               state_q, state_d;
  logic [15:0]          flow_q, flow_d;
  logic                 first_q, first_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [5:0]           alloc_q, alloc_d;
  logic [63:0]          valid_q;
  logic [15:0]          tag_mem [64];
  logic [NUM_REGEX-1:0] en_mem [64];
  logic                 rdy_q, load_q, cvld_q, cvld_d, eop_q, busy_q, new_q, new_d;
  logic [5:0]           sid_q, sid_d;
  logic [7:0]           char_q, char_d;
  logic [NUM_REGEX-1:0] en_q, en_d;
  logic [15:0]          drop_q, drop_d;
  logic                 hit, alloc_we, accept;
  logic [5:0]           hit_idx;
  // A sop beat is never consumed in IDLE, nor in STREAM once the held first beat has gone.
  assign in_rdy = rdy_q && !(in_sop && (state_q == IDLE || !first_q));
  assign accept = in_vld && in_rdy;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < 64; i++)
      if (valid_q[i] && tag_mem[i] == flow_q) begin
        hit = 1'b1;
        hit_idx = 6'(i);
      end
  end
  always_comb begin
    state_d = state_q;
    flow_d = flow_q;
    first_d = first_q;
    cnt_d = cnt_q;
    alloc_d = alloc_q;
    sid_d = sid_q;
    new_d = new_q;
    en_d = en_q;
    char_d = char_q;
    cvld_d = 1'b0;
    drop_d = drop_q;
    alloc_we = 1'b0;
    unique case (state_q)
      IDLE:
        if (in_vld && in_sop) begin
          flow_d = in_flow_tag;
          state_d = LOOKUP;
        end else if (accept) drop_d = drop_q + 16'(drop_q != 16'hFFFF);
      LOOKUP: begin
        state_d = LOAD;
        alloc_we = !hit;
        sid_d = hit ? hit_idx : alloc_q;
        new_d = !hit;
        en_d = hit ? en_mem[hit_idx] : DEFAULT_EN;
        alloc_d = hit ? alloc_q : alloc_q + 6'd1;
      end
      LOAD: state_d = SETTLE;
      SETTLE: begin
        state_d = STREAM;
        first_d = 1'b1;
      end
      STREAM: begin
        cnt_d = 4'(DRAIN_CYCLES);
        if (accept) begin
          char_d = in_data;
          cvld_d = 1'b1;
          first_d = 1'b0;
          state_d = in_eop ? DRAIN : STREAM;
        end else if (in_vld && in_sop) state_d = DRAIN;
      end
      // Entered on the cycle of the last char_in_vld, so one extra cycle is spent here.
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? EOP : DRAIN;
      end
      EOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flow_q <= '0;
      first_q <= 1'b0;
      cnt_q <= '0;
      alloc_q <= '0;
      valid_q <= '0;
      rdy_q <= 1'b0;
      load_q <= 1'b0;
      cvld_q <= 1'b0;
      eop_q <= 1'b0;
      busy_q <= 1'b0;
      new_q <= 1'b0;
      sid_q <= '0;
      char_q <= '0;
      en_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      flow_q <= flow_d;
      first_q <= first_d;
      cnt_q <= cnt_d;
      alloc_q <= alloc_d;
      if (alloc_we) valid_q[alloc_q] <= 1'b1;
      rdy_q <= state_d == IDLE || state_d == STREAM;
      load_q <= state_d == LOAD;
      cvld_q <= cvld_d;
      eop_q <= state_d == EOP;
      busy_q <= state_d != IDLE;
      new_q <= new_d;
      sid_q <= sid_d;
      char_q <= char_d;
      en_q <= en_d;
      drop_q <= drop_d;
    end
  end
  // A config write in the allocation cycle to the same entry lands last and wins.
  always_ff @(posedge clk) begin
    if (alloc_we) begin
      tag_mem[alloc_q] <= flow_q;
      en_mem[alloc_q] <= DEFAULT_EN;
    end
    if (cfg_we) en_mem[cfg_addr] <= cfg_en;
  end
  assign stream_id = sid_q;
  assign new_stream_id = new_q;
  assign load_state = load_q;
  assign char_in = char_q;
  assign char_in_vld = cvld_q;
  assign eop = eop_q;
  assign enable = en_q;
  assign busy = busy_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: scoreboard bench for dpi_stream_sequencer.
module tb_dpi_stream_sequencer;
  localparam int D = 2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, cfg_we = 1'b0;
  logic        in_rdy, new_stream_id, load_state, char_in_vld, eop, busy;
  logic [7:0]  in_data = '0, char_in, exp_b;
  logic [15:0] in_flow_tag = '0, drop_cnt;
  logic [5:0]  cfg_addr = '0, stream_id;
  logic [7:0]  cfg_en = '0, enable;
  int          checks = 0, errors = 0, cyc = 0, t_sop = 0, load_cyc = -1, eop_cyc = -1, eop_cnt = 0;
  logic [7:0]  exp_q[$];
  int          vld_cyc[$];

  dpi_stream_sequencer #(.NUM_REGEX(8), .DRAIN_CYCLES(D), .DEFAULT_EN(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_flow_tag(in_flow_tag), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .stream_id(stream_id), .new_stream_id(new_stream_id), .load_state(load_state), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .busy(busy), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (char_in_vld) begin
      vld_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL char_unexpected got %02h want none", char_in);
      end else begin
        exp_b = exp_q.pop_front();
        if (char_in !== exp_b) begin
          errors++;
          $display("FAIL char_data got %02h want %02h", char_in, exp_b);
        end
      end
    end
    if (load_state) load_cyc = cyc;
    if (eop) begin
      eop_cyc = cyc;
      eop_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic send_pkt(input logic [15:0] tag, input int n, input logic [7:0] base,
                          input bit last_eop, input int gap_at);
    logic rdy;
    int guard;
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
    vld_cyc.delete();
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_vld = 1'b0;
        @(negedge clk);
      end
      in_vld = 1'b1;
      in_sop = i == 0;
      in_eop = last_eop && i == n - 1;
      in_data = base + 8'(i);
      in_flow_tag = tag;
      if (i == 0) t_sop = cyc;
      guard = 0;
      forever begin
        #1 rdy = in_rdy;
        @(posedge clk);
        @(negedge clk);
        if (rdy) break;
        guard++;
        if (guard > 60) begin
          checks++;
          errors++;
          $display("FAIL beat_accept got none want accept (beat %0d)", i);
          break;
        end
      end
    end
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic wait_eop(input int target);
    int g = 0;
    while (eop_cnt < target && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checks++;
    if (eop_cnt != target) begin
      errors++;
      $display("FAIL eop_count got %0d want %0d", eop_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_meta(input string name, input logic [5:0] sid, input logic nw, input logic [7:0] en);
    checks++;
    if (stream_id !== sid || new_stream_id !== nw || enable !== en) begin
      errors++;
      $display("FAIL %s got sid=%0d new=%0b en=%02h want sid=%0d new=%0b en=%02h",
               name, stream_id, new_stream_id, enable, sid, nw, en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_rdy, load_state, char_in_vld, eop, busy, new_stream_id, stream_id, enable, drop_cnt, char_in} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b ld=%0b cv=%0b eop=%0b busy=%0b new=%0b sid=%0d en=%02h drop=%0d ch=%02h want all 0",
               in_rdy, load_state, char_in_vld, eop, busy, new_stream_id, stream_id, enable, drop_cnt, char_in);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_packet();
    int e0 = eop_cnt;
    send_pkt(16'h1234, 3, 8'h41, 1, -1);
    wait_eop(e0 + 1);
    check_meta("first_meta", 6'd0, 1'b1, 8'hFF);
    checks++;
    if (load_cyc != t_sop + 2) begin
      errors++;
      $display("FAIL first_load_cycle got %0d want %0d", load_cyc - t_sop, 2);
    end
    checks++;
    if (vld_cyc.size() != 3 || vld_cyc[0] != t_sop + 5 || vld_cyc[2] != t_sop + 7) begin
      errors++;
      $display("FAIL first_vld_cycles got n=%0d want n=3 at T+5..T+7", vld_cyc.size());
    end
    checks++;
    if (eop_cyc != t_sop + 8 + D) begin
      errors++;
      $display("FAIL first_eop_cycle got %0d want %0d", eop_cyc - t_sop, 8 + D);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_done got left=%0d busy=%0b want 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_hit_and_new();
    send_pkt(16'h1234, 2, 8'h20, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("hit_meta", 6'd0, 1'b0, 8'hFF);
    send_pkt(16'h5678, 2, 8'h30, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("new_meta", 6'd1, 1'b1, 8'hFF);
  endtask

  task automatic test_cfg_during();
    int e0 = eop_cnt;
    fork
      send_pkt(16'h1234, 4, 8'h10, 1, -1);
      begin
        repeat (7) @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 6'd0;
        cfg_en = 8'h05;
        @(negedge clk);
        cfg_we = 1'b0;
      end
    join
    wait_eop(e0 + 1);
    check_meta("cfg_current", 6'd0, 1'b0, 8'hFF);
    send_pkt(16'h1234, 1, 8'h18, 1, -1);
    wait_eop(e0 + 2);
    check_meta("cfg_next", 6'd0, 1'b0, 8'h05);
  endtask

  task automatic test_drop();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1;
      in_sop = 1'b0;
      in_data = 8'hEE;
      @(negedge clk);
    end
    in_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_count got %0d busy=%0b want 4 busy=0", drop_cnt, busy);
    end
  endtask

  task automatic test_truncate();
    int e0 = eop_cnt;
    send_pkt(16'h5678, 2, 8'h60, 0, -1);
    send_pkt(16'h9ABC, 3, 8'h70, 1, -1);
    wait_eop(e0 + 2);
    check_meta("trunc_second", 6'd2, 1'b1, 8'hFF);
    checks++;
    if (exp_q.size() != 0 || drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL trunc_bytes got left=%0d drop=%0d want 0 4", exp_q.size(), drop_cnt);
    end
  endtask

  task automatic test_bubble();
    send_pkt(16'h1234, 3, 8'h80, 1, 1);
    wait_eop(eop_cnt + 1);
    checks++;
    if (vld_cyc.size() != 3 || vld_cyc[0] != t_sop + 5 || vld_cyc[1] != t_sop + 7 || vld_cyc[2] != t_sop + 8) begin
      errors++;
      $display("FAIL bubble_pattern got n=%0d want vld at T+5,T+7,T+8", vld_cyc.size());
    end
  endtask

  task automatic test_reset_stream();
    int e0 = eop_cnt;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    in_vld = 1'b1;
    in_sop = 1'b1;
    in_flow_tag = 16'h1234;
    in_data = 8'hA0;
    repeat (5) @(negedge clk);
    in_sop = 1'b0;
    in_data = 8'hA1;
    @(negedge clk);
    in_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_rdy, load_state, char_in_vld, eop, busy, new_stream_id, stream_id, enable, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_stream_outputs got rdy=%0b ld=%0b cv=%0b eop=%0b busy=%0b new=%0b en=%02h drop=%0d want all 0",
               in_rdy, load_state, char_in_vld, eop, busy, new_stream_id, enable, drop_cnt);
    end
    rst_n = 1'b1;
    repeat (D + 10) @(negedge clk);
    checks++;
    if (eop_cnt != e0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_stream_no_eop got eops=%0d left=%0d want %0d 0", eop_cnt, exp_q.size(), e0);
    end
    send_pkt(16'h1234, 1, 8'hA5, 1, -1);
    wait_eop(e0 + 1);
    check_meta("rst_stream_miss", 6'd0, 1'b1, 8'hFF);
  endtask

  task automatic test_cfg_collision();
    fork
      send_pkt(16'hBEEF, 1, 8'hB0, 1, -1);
      begin
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 6'd1;
        cfg_en = 8'h3C;
        @(negedge clk);
        cfg_we = 1'b0;
      end
    join
    wait_eop(eop_cnt + 1);
    check_meta("collide_current", 6'd1, 1'b1, 8'hFF);
    send_pkt(16'hBEEF, 1, 8'hB1, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("collide_next", 6'd1, 1'b0, 8'h3C);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send_pkt(16'h1000 + 16'(i), 1, 8'(i), 1, -1);
      wait_eop(eop_cnt + 1);
    end
    send_pkt(16'h1040, 1, 8'hC0, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("wrap_65th", 6'd0, 1'b1, 8'hFF);
    send_pkt(16'h1000, 1, 8'hC1, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("wrap_evicted_first", 6'd1, 1'b1, 8'hFF);
    send_pkt(16'h1005, 1, 8'hC2, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("wrap_survivor_hit", 6'd5, 1'b0, 8'hFF);
    send_pkt(16'h1001, 1, 8'hC3, 1, -1);
    wait_eop(eop_cnt + 1);
    check_meta("wrap_second_evicted", 6'd2, 1'b1, 8'hFF);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_packet();
    test_hit_and_new();
    test_cfg_during();
    test_drop();
    test_truncate();
    test_bubble();
    test_reset_stream();
    test_cfg_collision();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpi_stream_sequencer.md
Name: dpi_stream_sequencer

Overview:
- Front-end controller for the per-regex matcher wrappers in the packet-inspection core.
- Accepts a byte stream of packets tagged with a 16-bit flow tag. Maps each flow tag to a 6-bit stream ID through a 64-entry stream table, allocating entries round-robin on a miss.
- Sequences the shared matcher control signals: stream_id, new_stream_id, load_state, char_in/char_in_vld, eop and a per-regex enable mask. Saved matcher state is restored before the first byte and saved after the last.

Parameters:
- NUM_REGEX, 8, number of matcher wrappers (width of enable mask).
- DRAIN_CYCLES, 2, idle cycles between the last char_in_vld and eop; covers matcher accept latency (range 1..15).
- DEFAULT_EN, {NUM_REGEX{1'b1}}, enable mask written into a newly allocated stream entry.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_vld  in  1  input byte valid.
- in_rdy  out  1  input byte accepted when in_vld&&in_rdy.
- in_sop  in  1  first byte of packet.
- in_eop  in  1  last byte of packet.
- in_data  in  8  packet byte.
- in_flow_tag  in  16  flow tag, valid on the in_sop beat.
- cfg_we  in  1  enable-mask write strobe.
- cfg_addr  in  6  stream entry to configure.
- cfg_en  in  NUM_REGEX  enable mask to write.
- stream_id  out  6  current stream ID to matchers.
- new_stream_id  out  1  current stream was just allocated.
- load_state  out  1  one-cycle restore pulse.
- char_in  out  8  byte to matchers.
- char_in_vld  out  1  char_in valid.
- eop  out  1  one-cycle end-of-packet pulse.
- enable  out  NUM_REGEX  per-regex enable for current stream.
- busy  out  1  FSM not in IDLE.
- drop_cnt  out  16  non-sop beats discarded in IDLE; saturating.

Behaviour:
- Reset values:
  - All outputs 0 (in_rdy, load_state, char_in_vld, eop, busy, new_stream_id, stream_id, enable, drop_cnt).
  - Table valid bits cleared; alloc_ptr = 0; FSM = IDLE.
  - Enable-mask memory is not reset.
  - Reset mid-packet abandons the packet: no eop is emitted.
- FSM states: IDLE, LOOKUP, LOAD, SETTLE, STREAM, DRAIN, EOP. All outputs are registered.
- IDLE:
  - in_rdy = 1 only for non-sop beats. Such beats are consumed and drop_cnt increments, saturating at 0xFFFF.
  - in_vld && in_sop: capture in_flow_tag, do not consume the beat, go to LOOKUP.
- LOOKUP, 1 cycle:
  - Compare the captured tag against all valid entries.
  - Hit at index i: stream_id <= i, new_stream_id <= 0, enable <= en_mem[i].
  - Miss: stream_id <= alloc_ptr, new_stream_id <= 1, entry valid and tag written, en_mem[alloc_ptr] <= DEFAULT_EN, enable <= DEFAULT_EN, alloc_ptr increments and wraps 63 -> 0.
  - Multiple hits cannot occur, because an allocation overwrites the victim's tag.
- LOAD, 1 cycle: load_state = 1.
- SETTLE, 1 cycle: covers the wrapper's state_in_vld cycle. No char is issued.
- STREAM:
  - in_rdy = 1. An accepted beat drives char_in <= in_data and char_in_vld <= 1 on the next cycle. char_in_vld = 0 on bubbles.
  - The first accepted beat is the held sop beat.
  - Accepted beat with in_eop: go to DRAIN.
  - in_sop seen on a beat after the first: that beat is not consumed (in_rdy deasserts combinationally on in_sop after the first beat). Treat it as truncation of the current packet and go to DRAIN; the new packet is then handled from IDLE.
  - A single beat with both in_sop and in_eop is a 1-byte packet.
- DRAIN: DRAIN_CYCLES cycles, counted from the cycle after the last char_in_vld. in_rdy = 0.
- EOP, 1 cycle: eop = 1, then IDLE. A new LOOKUP is therefore at least 1 cycle after eop, so the wrappers' state_mem write completes before the next restore read.
- Latency: sop presented in IDLE at cycle T gives LOOKUP at T+1, load_state at T+2, SETTLE at T+3, in_rdy at T+4, and the first char_in_vld at T+5.
- stream_id, new_stream_id and enable are held from LOOKUP until the next LOOKUP.
- Config writes:
  - A cfg_we write to en_mem takes effect at the next LOOKUP of that entry. The current packet's enable is not changed.
  - cfg_we in the same cycle as a LOOKUP allocation to the same index: cfg_en wins in en_mem, but the enable output for that packet is DEFAULT_EN.
- Table full: allocation evicts entry alloc_ptr regardless of validity. An evicted flow is reallocated later as new.

Test Plan:
- Reset, then sop with tag 0x1234, 3 bytes 0x41,0x42,0x43 (eop on the third) -> new_stream_id = 1, stream_id = 0, load_state pulse at T+2, char_in_vld at T+5..T+7, eop at T+7+DRAIN_CYCLES+1, enable = 0xFF.
- Second packet with tag 0x1234 -> stream_id = 0, new_stream_id = 0. A new tag 0x5678 -> stream_id = 1, new_stream_id = 1.
- cfg_we addr 0, en 0x05 during a 0x1234 packet -> current packet enable = 0xFF; the next 0x1234 packet has enable = 0x05.
- 65 distinct tags -> the 65th gets stream_id = 0 with new_stream_id = 1. Re-sending the first tag then misses and allocates stream_id = 1.
- 4 non-sop beats in IDLE -> drop_cnt = 4. A second in_sop mid-packet -> eop emitted for the first packet, the second packet is processed normally, and no bytes are lost.
- in_vld toggling 1-0-1 in STREAM -> char_in_vld shows a matching bubble. rst_n low in STREAM -> no eop, all outputs 0 the next cycle, and table lookups miss afterwards.
